// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma-key background source: pattern codes,
// pixel-format widths and the color-bar palette.
package chroma_pkg;

    localparam int PIX_W   = 16;   // bg_data / camera pixel word
    localparam int RGB_W   = 12;   // RGB444 payload
    localparam int COORD_W = 10;   // raster x/y counters
    localparam int FCNT_W  = 8;    // frame counter

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_GRAD  = 2'd3
    } pat_sel_e;

    // Classic eight-bar palette, left to right.
    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] idx);
        logic [RGB_W-1:0] c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bg_pattern_lut.sv
// Combinational pattern lookup: raster position plus pattern controls to one
// RGB444 value. Fed by the top's next-state counters so the result can be
// registered in the same cycle the position advances.
module bg_pattern_lut
    import chroma_pkg::*;
#(
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  pat_sel_e           sel,
    input  logic [RGB_W-1:0]   color,
    input  logic [FCNT_W-1:0]  frame_cnt,
    output logic [RGB_W-1:0]   rgb
);

    logic [2:0] bar_idx;
    logic       unused_bits;

    // Bits not consumed by any pattern, kept visible to lint as intentionally dropped.
    assign unused_bits = ^{y[9], y[4:0], frame_cnt[7:6], frame_cnt[1:0]};

    // Bar index from a chain of boundary compares; avoids a divider on x.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x >= COORD_W'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    // Pattern select.
    always_comb begin
        rgb = '0;
        case (sel)
            PAT_SOLID: rgb = color;
            PAT_BARS:  rgb = bar_color(bar_idx);
            PAT_CHECK: rgb = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 12'hFFF : 12'h000;
            PAT_GRAD:  rgb = {x[9:6], y[8:5], frame_cnt[5:2]};
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/chroma_bg_pattern_gen.sv
// Background-pixel source for the chroma-key mixer. Follows the camera raster
// from frame_start/pixel_valid and presents bg_data for the next pixel to be
// consumed, so the mixer sees it in the same cycle the camera pixel is valid.
// Pattern select and solid color are latched only at frame_start.
module chroma_bg_pattern_gen
    import chroma_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_frame_start,
    input  logic               i_pixel_valid,
    input  logic [1:0]         i_pattern_sel,
    input  logic [RGB_W-1:0]   i_solid_color,
    output logic [PIX_W-1:0]   bg_data,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_frame_done
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    logic [COORD_W-1:0] x_q, y_q, x_n, y_n;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_n;
    pat_sel_e           sel_q, sel_n;
    logic [RGB_W-1:0]   color_q, color_n;
    logic               done_n;
    logic [RGB_W-1:0]   rgb_n;

    // Next raster position, frame counter and shadow controls.
    always_comb begin
        x_n     = x_q;
        y_n     = y_q;
        fcnt_n  = fcnt_q;
        sel_n   = sel_q;
        color_n = color_q;
        done_n  = 1'b0;
        if (i_frame_start) begin
            // frame_start wins over a coincident valid; that pixel is not counted.
            x_n     = '0;
            y_n     = '0;
            sel_n   = pat_sel_e'(i_pattern_sel);
            color_n = i_solid_color;
        end else if (i_pixel_valid) begin
            if (x_q < X_LAST) begin
                x_n = x_q + 1'b1;
            end else begin
                x_n = '0;
                if (y_q < Y_LAST) begin
                    y_n = y_q + 1'b1;
                end else begin
                    y_n    = '0;
                    fcnt_n = fcnt_q + 1'b1;
                    done_n = 1'b1;
                end
            end
        end
    end

    bg_pattern_lut #(
        .BAR_W      (BAR_W),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_lut (
        .x         (x_n),
        .y         (y_n),
        .sel       (sel_n),
        .color     (color_n),
        .frame_cnt (fcnt_n),
        .rgb       (rgb_n)
    );

    // Counters, shadows and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q          <= '0;
            y_q          <= '0;
            fcnt_q       <= '0;
            sel_q        <= PAT_SOLID;
            color_q      <= '0;
            bg_data      <= '0;
            o_frame_done <= 1'b0;
        end else begin
            x_q          <= x_n;
            y_q          <= y_n;
            fcnt_q       <= fcnt_n;
            sel_q        <= sel_n;
            color_q      <= color_n;
            bg_data      <= {4'b0000, rgb_n};
            o_frame_done <= done_n;
        end
    end

    assign o_x = x_q;
    assign o_y = y_q;

endmodule
